// File: rtl/board_input_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : board_input_debounce_pkg
// Brief    : Shared constants for the board input conditioning stage:
//            button bit positions and the default debounce interval.
// Revision : 1.0 - initial release
// ============================================================================
package board_input_debounce_pkg;

  // Bit positions inside btn_raw / btn, ordered {s, l, r, u, d} MSB..LSB
  localparam int BTN_IDX_D = 0;
  localparam int BTN_IDX_U = 1;
  localparam int BTN_IDX_R = 2;
  localparam int BTN_IDX_L = 3;
  localparam int BTN_IDX_S = 4;

  localparam int BOARD_CLK_HZ = 100_000_000;
  localparam int DEBOUNCE_MS  = 10;

  function automatic int cycles_for_ms(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES = cycles_for_ms(BOARD_CLK_HZ, DEBOUNCE_MS);

endpackage : board_input_debounce_pkg
`default_nettype wire

// File: rtl/board_input_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : board_input_debounce_bit
// Brief    : One raw pin: two-flop synchroniser, stability counter, accepted
//            level and registered one-cycle rise/fall strobes.
// Revision : 1.0 - initial release
// ============================================================================
module board_input_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_BITS        = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_BITS-1:0] c_cnt_max = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                r_meta;
  logic                r_sync;
  logic                r_stable;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_rise;
  logic                r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      // Any return to the accepted level restarts the stability window
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_stable <= r_sync;
        r_cnt    <= '0;
        r_rise   <= r_sync;
        r_fall   <= ~r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : board_input_debounce_bit
`default_nettype wire

// File: rtl/board_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : board_input_debounce
// Brief    : Synchronises and debounces switch/button pins, producing clean
//            levels plus edge strobes and a combined change interrupt.
//            Optional button auto-repeat: BOARD_BTN_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_input_debounce
  import board_input_debounce_pkg::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int BTN_WIDTH       = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_BITS        = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef BOARD_BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW_WIDTH-1:0]  switch_raw,
  input  logic [BTN_WIDTH-1:0] btn_raw,
  output logic [SW_WIDTH-1:0]  switch,
  output logic [BTN_WIDTH-1:0] btn,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [SW_WIDTH-1:0]  sw_change,
  output logic                 change
);

  logic [SW_WIDTH-1:0]  w_sw_lvl;
  logic [SW_WIDTH-1:0]  w_sw_rise;
  logic [SW_WIDTH-1:0]  w_sw_fall;
  logic [BTN_WIDTH-1:0] w_btn_lvl;
  logic [BTN_WIDTH-1:0] w_btn_rise;
  logic [BTN_WIDTH-1:0] w_btn_fall;
  logic [BTN_WIDTH-1:0] w_btn_press;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    board_input_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
    ) u_debounce_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (switch_raw[i]),
      .o_level (w_sw_lvl[i]),
      .o_rise  (w_sw_rise[i]),
      .o_fall  (w_sw_fall[i])
    );
  end : g_sw

  for (genvar j = 0; j < BTN_WIDTH; j++) begin : g_btn
    board_input_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
    ) u_debounce_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_raw[j]),
      .o_level (w_btn_lvl[j]),
      .o_rise  (w_btn_rise[j]),
      .o_fall  (w_btn_fall[j])
    );
  end : g_btn

`ifdef BOARD_BTN_AUTOREPEAT_EN
  localparam int c_hold_span = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_hold_bits = $clog2(c_hold_span + 1);
  localparam logic [c_hold_bits-1:0] c_delay_m1  = c_hold_bits'(REPEAT_DELAY - 1);
  localparam logic [c_hold_bits-1:0] c_period_m1 = c_hold_bits'(REPEAT_PERIOD - 1);

  logic [BTN_WIDTH-1:0] w_rep;

  for (genvar j = 0; j < BTN_WIDTH; j++) begin : g_rep
    logic [c_hold_bits-1:0] r_hold;
    logic                   r_phase;
    logic                   r_rep;
    logic [c_hold_bits-1:0] w_thr;

    // First repeat waits the long delay, later ones the short period
    assign w_thr = r_phase ? c_period_m1 : c_delay_m1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hold  <= '0;
        r_phase <= 1'b0;
        r_rep   <= 1'b0;
      end else if (!w_btn_lvl[j]) begin
        r_hold  <= '0;
        r_phase <= 1'b0;
        r_rep   <= 1'b0;
      end else if (r_hold == w_thr) begin
        r_hold  <= '0;
        r_phase <= 1'b1;
        r_rep   <= 1'b1;
      end else begin
        r_hold  <= r_hold + 1'b1;
        r_rep   <= 1'b0;
      end
    end

    assign w_rep[j] = r_rep;
  end : g_rep

  // Masking with the level drops a repeat that lands on the release edge
  assign w_btn_press = w_btn_rise | (w_rep & w_btn_lvl);
`else
  assign w_btn_press = w_btn_rise;
`endif

  assign switch      = w_sw_lvl;
  assign btn         = w_btn_lvl;
  assign btn_press   = w_btn_press;
  assign btn_release = w_btn_fall;
  assign sw_change   = w_sw_rise | w_sw_fall;
  assign change      = |{w_btn_press, w_btn_fall, w_sw_rise, w_sw_fall};

endmodule : board_input_debounce
`default_nettype wire

// File: tb/tb_board_input_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_input_debounce
// Brief    : Randomised bench with a sliding-window reference model and a
//            pulse scoreboard for board_input_debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_input_debounce;

  localparam int SW  = 8;
  localparam int BTN = 5;
  localparam int DEB = 8;
  localparam int NB  = SW + BTN;
`ifdef BOARD_BTN_AUTOREPEAT_EN
  localparam int RDLY = 20;
  localparam int RPER = 5;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [SW-1:0]  switch_raw = '0;
  logic [BTN-1:0] btn_raw = '0;
  logic [SW-1:0]  switch;
  logic [BTN-1:0] btn;
  logic [BTN-1:0] btn_press;
  logic [BTN-1:0] btn_release;
  logic [SW-1:0]  sw_change;
  logic           change;

  always #5 clk = ~clk;

  board_input_debounce #(
    .SW_WIDTH        (SW),
    .BTN_WIDTH       (BTN),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_BITS        ($clog2(DEB + 1))
`ifdef BOARD_BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .switch_raw  (switch_raw),
    .btn_raw     (btn_raw),
    .switch      (switch),
    .btn         (btn),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw_change   (sw_change),
    .change      (change)
  );

  typedef struct {
    int             cyc;
    logic [SW-1:0]  sw_chg;
    logic [BTN-1:0] press;
    logic [BTN-1:0] rel;
  } ev_t;

  ev_t           exp_q[$];
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_lvl = '0;
  int            press_cyc[BTN];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a bit's level flips once the D synchronised samples seen by
  // the last D comparisons (raw samples 2..D+1 edges old) all differ from it.
  initial begin : model
    ev_t  ev;
    logic any;
    logic flip;
    int   el;
    for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        hist.delete();
        for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
        m_lvl = '0;
      end else begin
        cyc++;
        hist.push_back({btn_raw, switch_raw});
        void'(hist.pop_front());
        ev.cyc = cyc; ev.sw_chg = '0; ev.press = '0; ev.rel = '0;
        any = 1'b0;
        for (int b = 0; b < NB; b++) begin
          flip = 1'b1;
          for (int k = 2; k <= DEB + 1; k++)
            if (hist[hist.size() - 1 - k][b] == m_lvl[b]) flip = 1'b0;
          if (flip) begin
            m_lvl[b] = ~m_lvl[b];
            any = 1'b1;
            if (b < SW) ev.sw_chg[b] = 1'b1;
            else if (m_lvl[b]) begin
              ev.press[b - SW] = 1'b1;
              press_cyc[b - SW] = cyc;
            end else ev.rel[b - SW] = 1'b1;
          end
        end
`ifdef BOARD_BTN_AUTOREPEAT_EN
        for (int j = 0; j < BTN; j++) begin
          if (m_lvl[SW + j]) begin
            el = cyc - press_cyc[j];
            if (el >= RDLY && ((el - RDLY) % RPER) == 0) begin
              ev.press[j] = 1'b1;
              any = 1'b1;
            end
          end
        end
`endif
        if (any) exp_q.push_back(ev);
      end
    end
  end

  initial begin : monitor
    ev_t mev;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mev = exp_q.pop_front();
        chk("change", {31'b0, change}, 32'd1);
        chk("sw_change", {24'b0, sw_change}, {24'b0, mev.sw_chg});
        chk("btn_press", {27'b0, btn_press}, {27'b0, mev.press});
        chk("btn_release", {27'b0, btn_release}, {27'b0, mev.rel});
      end else begin
        chk("idle_pulses", {13'b0, change, sw_change, btn_press, btn_release}, 32'd0);
      end
      chk("levels", {19'b0, btn, switch}, {19'b0, m_lvl});
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hold_left[NB];
    logic [NB-1:0] vals;
    logic [4:0] bounce;

    // Reset with switches high: nothing may leak out during or right after reset
    rst_n = 1'b0; switch_raw = 8'hA5; btn_raw = '0;
    step(3);
    chk("reset_outputs", {switch, btn, btn_press, btn_release, sw_change, change}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("reset_release_latency", {24'b0, switch}, (k == 10) ? 32'hA5 : 32'h0);
    end
    step(3);

    // Short glitch on btn_s never becomes a level
    btn_raw[4] = 1'b1; step(5);
    btn_raw[4] = 1'b0; step(14);
    chk("glitch_btn_s", {31'b0, btn[4]}, 32'd0);

    // Bounce on btn_d, then held: level follows the last rising raw edge
    bounce = 5'b01101;
    for (int k = 0; k < 5; k++) begin
      btn_raw[0] = bounce[k];
      step(1);
    end
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("bounce_latency", {31'b0, btn[0]}, (k == 10) ? 32'd1 : 32'd0);
    end
    step(4);

    // Press and release btn_u
    btn_raw[1] = 1'b1; step(14);
    btn_raw[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("release_latency", {31'b0, btn[1]}, (k < 10) ? 32'd1 : 32'd0);
    end
    step(4);

    // Switch and button stepping together share one change pulse
    switch_raw[3] = 1'b1; btn_raw[2] = 1'b1;
    step(14);

    // Reset in the middle of a debounce window discards the progress
    btn_raw[3] = 1'b1; step(7);
    rst_n = 1'b0; step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("reset_restart", {31'b0, btn[3]}, (k == 10) ? 32'd1 : 32'd0);
    end
    step(40);

    // Random per-bit hold times, mixing bounces and accepted levels
    for (int k = 0; k < NB; k++) hold_left[k] = 0;
    vals = {btn_raw, switch_raw};
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NB; b++) begin
        if (hold_left[b] == 0) begin
          vals[b] = 1'($urandom_range(0, 1));
          hold_left[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(9, 40))
                                                     : int'($urandom_range(1, 8));
        end else begin
          hold_left[b]--;
        end
      end
      {btn_raw, switch_raw} = vals;
      if (c == 1000) begin
        rst_n = 1'b0; step(1);
        rst_n = 1'b1;
      end
      step(1);
    end

    switch_raw = '0; btn_raw = '0;
    step(20);
    chk("final_levels", {19'b0, btn, switch}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_board_input_debounce
`default_nettype wire
